traffic_light_monitor: RTL and testbench
========================================

# traffic_light_monitor

Receive-side checker for the 2-bit traffic-light code driven by the light-sequence generator. Each qualified sample is decoded into registered one-hot lamp drives. The block checks the sample stream for legal RED→GREEN→YELLOW→RED order, legal codes and per-phase dwell bounds, and counts completed cycles. On any violation it latches a sticky error and forces a fail-safe red lamp until software clears it.

## Interface
- MIN_DWELL, default 1: minimum valid samples a phase must last before it may change.
- MAX_DWELL, default 15: maximum valid samples a phase may last; requires 1 ≤ MIN_DWELL ≤ MAX_DWELL.
- DWELL_W, default 4: dwell counter width; must hold MAX_DWELL.
- CNT_W, default 8: completed-cycle counter width.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- light_in  in  2  light code: RED=2'b00, GREEN=2'b01, YELLOW=2'b10; 2'b11 is illegal.
- valid_in  in  1  qualifies light_in this cycle; samples with valid_in=0 are ignored.
- err_clr  in  1  single-cycle pulse; leaves FAULT and clears the sticky flags.
- lamp_red, lamp_green, lamp_yellow  out  1 each  registered lamp drives.
- locked  out  1  high while in TRACK.
- seq_err  out  1  sticky flag: illegal transition.
- code_err  out  1  sticky flag: code 2'b11 received.
- dwell_err  out  1  sticky flag: dwell bound violated.
- cycle_cnt  out  CNT_W  count of completed YELLOW→RED cycles; wraps.

## Operation
- Monitor FSM states are ACQUIRE, TRACK and FAULT. Registers: prev (phase), dwell (DWELL_W bits), cycle_cnt.
- ACQUIRE:
  - A valid RED sample moves the FSM to TRACK with prev=RED and dwell=1.
  - A valid GREEN or YELLOW sample is ignored; the FSM stays in ACQUIRE.
  - A valid 2'b11 sample sets code_err and moves the FSM to FAULT.
- TRACK, evaluated on each valid sample, in this priority order:
  1. Code 2'b11: set code_err, go to FAULT.
  2. Same phase as prev: if dwell==MAX_DWELL, set dwell_err and go to FAULT; otherwise increment dwell.
  3. Legal successor (RED→GREEN, GREEN→YELLOW, YELLOW→RED):
     - if dwell<MIN_DWELL, set dwell_err and go to FAULT;
     - otherwise set prev to the new phase and dwell=1, and on YELLOW→RED increment cycle_cnt (modulo 2^CNT_W).
  4. Any other phase change: set seq_err, go to FAULT.
- FAULT:
  - No checking is performed.
  - Lamps are forced to red only.
  - err_clr clears all three flags and moves the FSM to ACQUIRE.
- err_clr outside FAULT has no effect.
- Lamp outputs by state:
  - ACQUIRE and TRACK: one-hot decode of the last valid legal sample. The value holds while valid_in=0. An illegal code drives all lamps off in the same registered update that enters FAULT; red is forced from the next cycle.
  - FAULT: lamp_red=1, lamp_green=0, lamp_yellow=0.
- Exactly one error flag is set per FAULT entry.
- cycle_cnt is cleared only by reset.

## Timing
- Reset values: state=ACQUIRE, prev=RED, dwell=0, cycle_cnt=0, all flags 0, locked=0, all lamps 0.
- All outputs are registered. A sample on edge N is reflected in lamps, flags, locked and cycle_cnt after edge N; latency is 1 cycle.
- FAULT entry and the flag set occur on the same edge. Red forcing is visible from the next cycle.
- err_clr sampled on edge N clears the flags and sets state=ACQUIRE after edge N. A valid RED sample on edge N+1 relocks.
- Reset asserted mid-operation returns every register to its reset value immediately, without waiting for a clock edge.
- A dwell of exactly MAX_DWELL samples is legal; the MAX_DWELL+1-th same-phase sample faults.
- A phase change at exactly dwell==MIN_DWELL is legal.

## Structure
- The shared package traffic_light_pkg holds:
  - the light state_t enum (RED, GREEN, YELLOW), the same one used by the generator;
  - mon_state_t (ACQUIRE, TRACK, FAULT);
  - the function next_light(state_t) returning the legal successor.
- Single module; no sub-module is warranted.

## Test plan
- Reset, then feed RED,GREEN,YELLOW,RED with valid_in=1 each cycle and MIN=1, MAX=15 → locked=1 from the first RED, lamps follow one cycle later, cycle_cnt=1, no flags.
- In TRACK, feed GREEN with prev=RED then RED → seq_err=1, FAULT, lamp_red=1 from the next cycle; pulse err_clr, then send RED → seq_err=0, locked=1.
- Feed code 2'b11 in TRACK → code_err=1; also 2'b11 during ACQUIRE → code_err=1.
- MAX_DWELL=3: four consecutive valid GREEN samples → dwell_err on the fourth. With MIN_DWELL=2: RED then GREEN → dwell_err.
- Toggle valid_in=0 between samples → lamps and dwell unchanged. Run 256 cycles with CNT_W=8 → cycle_cnt wraps to 0.
- Assert rst_n low mid-cycle while in TRACK → all outputs 0 asynchronously. Release, then send GREEN → stays in ACQUIRE, locked=0.

Source files
------------

// File: rtl/traffic_light_pkg.sv
// rtl/traffic_light_pkg.sv - shared light-code and monitor types for the traffic-light blocks
package traffic_light_pkg;

    typedef enum logic [1:0] {
        RED    = 2'b00,
        GREEN  = 2'b01,
        YELLOW = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        ACQUIRE = 2'b00,
        TRACK   = 2'b01,
        FAULT   = 2'b10
    } mon_state_t;

    localparam logic [1:0] CODE_ILLEGAL = 2'b11;

    // Lamp vectors are ordered {red, green, yellow}.
    localparam logic [2:0] LAMPS_OFF = 3'b000;
    localparam logic [2:0] LAMPS_RED = 3'b100;

    function automatic state_t next_light(input state_t s);
        case (s)
            RED:     return GREEN;
            GREEN:   return YELLOW;
            default: return RED;
        endcase
    endfunction

    function automatic logic [2:0] lamp_decode(input state_t s);
        case (s)
            RED:     return 3'b100;
            GREEN:   return 3'b010;
            YELLOW:  return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - light-sequence checker with dwell bounds, sticky errors and fail-safe red
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter int MIN_DWELL = 1,
    parameter int MAX_DWELL = 15,
    parameter int DWELL_W   = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       light_in,
    input  logic             valid_in,
    input  logic             err_clr,
    output logic             lamp_red,
    output logic             lamp_green,
    output logic             lamp_yellow,
    output logic             locked,
    output logic             seq_err,
    output logic             code_err,
    output logic             dwell_err,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam logic [DWELL_W-1:0] L_MIN_DWELL = DWELL_W'(MIN_DWELL);
    localparam logic [DWELL_W-1:0] L_MAX_DWELL = DWELL_W'(MAX_DWELL);
    localparam logic [DWELL_W-1:0] L_DWELL_ONE = DWELL_W'(1);
    localparam logic [CNT_W-1:0]   L_CNT_ONE   = CNT_W'(1);

    mon_state_t       r_state;
    state_t           r_prev;
    logic [DWELL_W-1:0] r_dwell;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [2:0]       r_lamps;
    logic             r_seq_err;
    logic             r_code_err;
    logic             r_dwell_err;

    mon_state_t       w_state_nxt;
    state_t           w_prev_nxt;
    logic [DWELL_W-1:0] w_dwell_nxt;
    logic [CNT_W-1:0] w_cycle_cnt_nxt;
    logic [2:0]       w_lamps_nxt;
    logic             w_seq_err_nxt;
    logic             w_code_err_nxt;
    logic             w_dwell_err_nxt;
    logic             w_code_ok;
    state_t           w_sample;

    assign w_code_ok = (light_in != CODE_ILLEGAL);
    assign w_sample  = state_t'(light_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ACQUIRE;
            r_prev      <= RED;
            r_dwell     <= '0;
            r_cycle_cnt <= '0;
            r_lamps     <= LAMPS_OFF;
            r_seq_err   <= 1'b0;
            r_code_err  <= 1'b0;
            r_dwell_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_prev      <= w_prev_nxt;
            r_dwell     <= w_dwell_nxt;
            r_cycle_cnt <= w_cycle_cnt_nxt;
            r_lamps     <= w_lamps_nxt;
            r_seq_err   <= w_seq_err_nxt;
            r_code_err  <= w_code_err_nxt;
            r_dwell_err <= w_dwell_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_prev_nxt      = r_prev;
        w_dwell_nxt     = r_dwell;
        w_cycle_cnt_nxt = r_cycle_cnt;
        w_lamps_nxt     = r_lamps;
        w_seq_err_nxt   = r_seq_err;
        w_code_err_nxt  = r_code_err;
        w_dwell_err_nxt = r_dwell_err;

        case (r_state)
            ACQUIRE: begin
                if (valid_in) begin
                    if (!w_code_ok) begin
                        w_code_err_nxt = 1'b1;
                        w_lamps_nxt    = LAMPS_OFF;
                        w_state_nxt    = FAULT;
                    end else begin
                        // Non-red codes still drive the lamps; only red may start a lock.
                        w_lamps_nxt = lamp_decode(w_sample);
                        if (w_sample == RED) begin
                            w_state_nxt = TRACK;
                            w_prev_nxt  = RED;
                            w_dwell_nxt = L_DWELL_ONE;
                        end
                    end
                end
            end

            TRACK: begin
                if (valid_in) begin
                    if (!w_code_ok) begin
                        w_code_err_nxt = 1'b1;
                        w_lamps_nxt    = LAMPS_OFF;
                        w_state_nxt    = FAULT;
                    end else begin
                        w_lamps_nxt = lamp_decode(w_sample);
                        if (w_sample == r_prev) begin
                            if (r_dwell == L_MAX_DWELL) begin
                                w_dwell_err_nxt = 1'b1;
                                w_state_nxt     = FAULT;
                            end else begin
                                w_dwell_nxt = r_dwell + L_DWELL_ONE;
                            end
                        end else if (w_sample == next_light(r_prev)) begin
                            if (r_dwell < L_MIN_DWELL) begin
                                w_dwell_err_nxt = 1'b1;
                                w_state_nxt     = FAULT;
                            end else begin
                                w_prev_nxt  = w_sample;
                                w_dwell_nxt = L_DWELL_ONE;
                                if (r_prev == YELLOW) begin
                                    w_cycle_cnt_nxt = r_cycle_cnt + L_CNT_ONE;
                                end
                            end
                        end else begin
                            w_seq_err_nxt = 1'b1;
                            w_state_nxt   = FAULT;
                        end
                    end
                end
            end

            FAULT: begin
                w_lamps_nxt = LAMPS_RED;
                if (err_clr) begin
                    w_seq_err_nxt   = 1'b0;
                    w_code_err_nxt  = 1'b0;
                    w_dwell_err_nxt = 1'b0;
                    w_state_nxt     = ACQUIRE;
                end
            end

            default: begin
                w_state_nxt = ACQUIRE;
            end
        endcase
    end

    assign lamp_red    = r_lamps[2];
    assign lamp_green  = r_lamps[1];
    assign lamp_yellow = r_lamps[0];
    assign locked      = (r_state == TRACK);
    assign seq_err     = r_seq_err;
    assign code_err    = r_code_err;
    assign dwell_err   = r_dwell_err;
    assign cycle_cnt   = r_cycle_cnt;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb/tb_traffic_light_monitor.sv - vector table and scoreboard bench for traffic_light_monitor
module tb_traffic_light_monitor;

    // exp packs {lamp r,g,y, locked, seq,code,dwell flags, cycle_cnt[7:0]}
    typedef struct {
        bit         sel;
        bit         v;
        logic [1:0] l;
        bit         c;
        logic [14:0] exp;
    } vec_t;

    logic       clk;
    logic       rst_n;

    logic [1:0] a_light;
    logic       a_valid, a_clr;
    logic       a_red, a_green, a_yellow, a_locked, a_seq, a_code, a_dwell;
    logic [7:0] a_cnt;

    logic [1:0] b_light;
    logic       b_valid, b_clr;
    logic       b_red, b_green, b_yellow, b_locked, b_seq, b_code, b_dwell;
    logic [7:0] b_cnt;

    int checks = 0;
    int errors = 0;
    logic [14:0] sb[$];
    vec_t tbl_a[$];
    vec_t tbl_b[$];
    logic [7:0] exp_cnt;

    traffic_light_monitor #(.MIN_DWELL(1), .MAX_DWELL(15), .DWELL_W(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .light_in(a_light), .valid_in(a_valid), .err_clr(a_clr),
        .lamp_red(a_red), .lamp_green(a_green), .lamp_yellow(a_yellow), .locked(a_locked),
        .seq_err(a_seq), .code_err(a_code), .dwell_err(a_dwell), .cycle_cnt(a_cnt)
    );

    traffic_light_monitor #(.MIN_DWELL(2), .MAX_DWELL(3), .DWELL_W(4), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .light_in(b_light), .valid_in(b_valid), .err_clr(b_clr),
        .lamp_red(b_red), .lamp_green(b_green), .lamp_yellow(b_yellow), .locked(b_locked),
        .seq_err(b_seq), .code_err(b_code), .dwell_err(b_dwell), .cycle_cnt(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input bit sel, input bit v, input logic [1:0] l, input bit c,
                                input logic [2:0] lamps, input bit lk, input logic [2:0] fl,
                                input logic [7:0] cnt);
        vec_t r;
        r.sel = sel; r.v = v; r.l = l; r.c = c;
        r.exp = {lamps, lk, fl, cnt};
        return r;
    endfunction

    function automatic logic [14:0] obs(input bit sel);
        if (sel) return {b_red, b_green, b_yellow, b_locked, b_seq, b_code, b_dwell, b_cnt};
        return {a_red, a_green, a_yellow, a_locked, a_seq, a_code, a_dwell, a_cnt};
    endfunction

    task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%b exp=%b (lamps rgy,locked,seq code dwell,cnt)", name, act, exp);
        end
    endtask

    task automatic step(input string name, input vec_t v);
        logic [14:0] e;
        a_valid = 1'b0; a_light = 2'b00; a_clr = 1'b0;
        b_valid = 1'b0; b_light = 2'b00; b_clr = 1'b0;
        if (v.sel) begin
            b_valid = v.v; b_light = v.l; b_clr = v.c;
        end else begin
            a_valid = v.v; a_light = v.l; a_clr = v.c;
        end
        sb.push_back(v.exp);
        @(posedge clk);
        @(negedge clk);
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            check(name, obs(v.sel), e);
        end
    endtask

    initial begin
        // Main instance, MIN=1 MAX=15.
        tbl_a.push_back(mk(0,1,2'b00,0, 3'b100,1,3'b000,8'd0));
        tbl_a.push_back(mk(0,1,2'b01,0, 3'b010,1,3'b000,8'd0));
        tbl_a.push_back(mk(0,1,2'b10,0, 3'b001,1,3'b000,8'd0));
        tbl_a.push_back(mk(0,1,2'b00,0, 3'b100,1,3'b000,8'd1));
        tbl_a.push_back(mk(0,0,2'b01,0, 3'b100,1,3'b000,8'd1));
        tbl_a.push_back(mk(0,1,2'b01,0, 3'b010,1,3'b000,8'd1));
        tbl_a.push_back(mk(0,0,2'b11,0, 3'b010,1,3'b000,8'd1));
        tbl_a.push_back(mk(0,1,2'b01,0, 3'b010,1,3'b000,8'd1));
        tbl_a.push_back(mk(0,1,2'b00,0, 3'b100,0,3'b100,8'd1));
        tbl_a.push_back(mk(0,1,2'b01,0, 3'b100,0,3'b100,8'd1));
        tbl_a.push_back(mk(0,0,2'b00,1, 3'b100,0,3'b000,8'd1));
        tbl_a.push_back(mk(0,1,2'b00,0, 3'b100,1,3'b000,8'd1));
        tbl_a.push_back(mk(0,1,2'b11,0, 3'b000,0,3'b010,8'd1));
        tbl_a.push_back(mk(0,0,2'b00,0, 3'b100,0,3'b010,8'd1));
        tbl_a.push_back(mk(0,0,2'b00,1, 3'b100,0,3'b000,8'd1));
        tbl_a.push_back(mk(0,1,2'b11,0, 3'b000,0,3'b010,8'd1));
        tbl_a.push_back(mk(0,0,2'b00,1, 3'b100,0,3'b000,8'd1));
        tbl_a.push_back(mk(0,1,2'b01,0, 3'b010,0,3'b000,8'd1));
        tbl_a.push_back(mk(0,1,2'b10,0, 3'b001,0,3'b000,8'd1));
        tbl_a.push_back(mk(0,1,2'b00,0, 3'b100,1,3'b000,8'd1));
        tbl_a.push_back(mk(0,1,2'b10,0, 3'b001,0,3'b100,8'd1));
        tbl_a.push_back(mk(0,1,2'b00,1, 3'b100,0,3'b000,8'd1));
        tbl_a.push_back(mk(0,1,2'b00,0, 3'b100,1,3'b000,8'd1));
        tbl_a.push_back(mk(0,0,2'b00,1, 3'b100,1,3'b000,8'd1));

        // Second instance, MIN=2 MAX=3.
        tbl_b.push_back(mk(1,1,2'b00,0, 3'b100,1,3'b000,8'd0));
        tbl_b.push_back(mk(1,1,2'b01,0, 3'b010,0,3'b001,8'd0));
        tbl_b.push_back(mk(1,0,2'b00,1, 3'b100,0,3'b000,8'd0));
        tbl_b.push_back(mk(1,1,2'b00,0, 3'b100,1,3'b000,8'd0));
        tbl_b.push_back(mk(1,1,2'b00,0, 3'b100,1,3'b000,8'd0));
        tbl_b.push_back(mk(1,1,2'b01,0, 3'b010,1,3'b000,8'd0));
        tbl_b.push_back(mk(1,1,2'b01,0, 3'b010,1,3'b000,8'd0));
        tbl_b.push_back(mk(1,1,2'b01,0, 3'b010,1,3'b000,8'd0));
        tbl_b.push_back(mk(1,1,2'b01,0, 3'b010,0,3'b001,8'd0));
        tbl_b.push_back(mk(1,0,2'b00,0, 3'b100,0,3'b001,8'd0));

        rst_n = 1'b0;
        a_valid = 1'b0; a_light = 2'b00; a_clr = 1'b0;
        b_valid = 1'b0; b_light = 2'b00; b_clr = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_a", obs(0), 15'd0);
        check("reset_b", obs(1), 15'd0);
        rst_n = 1'b1;

        foreach (tbl_a[i]) step($sformatf("main[%0d]", i), tbl_a[i]);
        foreach (tbl_b[i]) step($sformatf("dwell_inst[%0d]", i), tbl_b[i]);

        // MAX_DWELL boundary: dwell is 1 after the last table entry, 14 more reds reach 15.
        for (int k = 0; k < 14; k++)
            step($sformatf("max_dwell_ok[%0d]", k), mk(0,1,2'b00,0, 3'b100,1,3'b000,8'd1));
        step("max_dwell_fault", mk(0,1,2'b00,0, 3'b100,0,3'b001,8'd1));
        step("max_dwell_clr",   mk(0,0,2'b00,1, 3'b100,0,3'b000,8'd1));
        step("relock",          mk(0,1,2'b00,0, 3'b100,1,3'b000,8'd1));

        // Counter wrap: 255 more cycles on top of the one already counted.
        exp_cnt = 8'd1;
        for (int k = 0; k < 255; k++) begin
            step($sformatf("wrap_g[%0d]", k), mk(0,1,2'b01,0, 3'b010,1,3'b000,exp_cnt));
            step($sformatf("wrap_y[%0d]", k), mk(0,1,2'b10,0, 3'b001,1,3'b000,exp_cnt));
            exp_cnt = exp_cnt + 8'd1;
            step($sformatf("wrap_r[%0d]", k), mk(0,1,2'b00,0, 3'b100,1,3'b000,exp_cnt));
        end
        check("wrap_zero", obs(0), {3'b100, 1'b1, 3'b000, 8'd0});

        // Asynchronous reset mid-cycle while locked.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_a", obs(0), 15'd0);
        check("async_reset_b", obs(1), 15'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_reset_green", mk(0,1,2'b01,0, 3'b010,0,3'b000,8'd0));
        step("post_reset_red",   mk(0,1,2'b00,0, 3'b100,1,3'b000,8'd0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
